// File: rtl/averager_sequencer_if.sv
// Control/status bundle between the sample-strobe source, averager sequencer and host.
// master drives strobes and configuration; slave (the sequencer) drives counters and status.
interface averager_sequencer_if #(
  parameter int unsigned FAST_COUNT_WIDTH = 13,
  parameter int unsigned SLOW_COUNT_WIDTH = 19
);
  logic                          clken;
  logic                          restart;
  logic                          stop;
  logic [FAST_COUNT_WIDTH-1:0]   count_max;
  logic [SLOW_COUNT_WIDTH-1:0]   n_avg_max;
  logic [FAST_COUNT_WIDTH-1:0]   fast_count;
  logic [SLOW_COUNT_WIDTH-1:0]   slow_count;
  logic                          init;
  logic                          wen;
  logic                          ready;
  logic [SLOW_COUNT_WIDTH-1:0]   n_avg;
  logic                          overflow;
  logic                          bank;
  logic [FAST_COUNT_WIDTH+1:0]   address;

  modport master (
    output clken, restart, stop, count_max, n_avg_max,
    input  fast_count, slow_count, init, wen, ready, n_avg, overflow, bank, address
  );

  modport slave (
    input  clken, restart, stop, count_max, n_avg_max,
    output fast_count, slow_count, init, wen, ready, n_avg, overflow, bank, address
  );
endinterface

// File: rtl/averager_sequencer.sv
// Averager sequencer: fast (sample) / slow (cycle) counters driving accumulator wen/init/address.
// Define AVG_PING_PONG_EN to toggle the BRAM bank on every completed run.
module averager_sequencer #(
  parameter int unsigned FAST_COUNT_WIDTH = 13,
  parameter int unsigned SLOW_COUNT_WIDTH = 19
) (
  input logic           clk,
  input logic           resetn,
  averager_sequencer_if.slave bus
);
  localparam int unsigned Fcw = FAST_COUNT_WIDTH;
  localparam int unsigned Scw = SLOW_COUNT_WIDTH;

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

  state_e         state_q;
  logic           clken_q;
  logic [Fcw-1:0] fast_q;
  logic [Fcw-1:0] count_max_q;
  logic [Scw-1:0] slow_q;
  logic [Scw-1:0] n_avg_q;
  logic           init_q;
  logic           wen_q;
  logic           ready_q;
  logic           overflow_q;
  logic           stop_pend_q;

  logic           boundary;
  logic           slow_full;
  logic [Scw-1:0] slow_sat;
  logic           hit_target;
  logic           done;
  logic           complete;

  always_comb begin
    boundary  = clken_q && (fast_q == count_max_q);
    slow_full = &slow_q;
    slow_sat  = slow_full ? slow_q : slow_q + Scw'(1);
    // Equality-only target: lowering n_avg_max below slow_count+1 leaves the run to stop.
    hit_target = (bus.n_avg_max != '0) && !slow_full && ((slow_q + Scw'(1)) == bus.n_avg_max);
    done       = hit_target || stop_pend_q;
    complete   = (state_q == StRun) && !bus.restart && boundary && done;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      clken_q     <= 1'b0;
      fast_q      <= '0;
      count_max_q <= '1;
      slow_q      <= '0;
      n_avg_q     <= '0;
      init_q      <= 1'b0;
      wen_q       <= 1'b0;
      ready_q     <= 1'b1;
      overflow_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      clken_q <= bus.clken;
      if (clken_q) begin
        fast_q <= boundary ? '0 : fast_q + Fcw'(1);
      end
      // Cycle length is frozen for the duration of a run.
      if (boundary && (state_q != StRun)) begin
        count_max_q <= bus.count_max;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.restart) begin
            state_q <= StArmed;
            ready_q <= 1'b0;
          end
        end
        StArmed: begin
          if (boundary) begin
            state_q    <= StRun;
            wen_q      <= 1'b1;
            init_q     <= 1'b1;
            slow_q     <= '0;
            overflow_q <= 1'b0;
          end
        end
        StRun: begin
          if (bus.restart) begin
            state_q     <= StArmed;
            wen_q       <= 1'b0;
            init_q      <= 1'b0;
            slow_q      <= '0;
            stop_pend_q <= 1'b0;
          end else if (boundary && done) begin
            state_q     <= StIdle;
            wen_q       <= 1'b0;
            init_q      <= 1'b0;
            ready_q     <= 1'b1;
            n_avg_q     <= slow_sat;
            slow_q      <= '0;
            stop_pend_q <= 1'b0;
          end else begin
            if (boundary) begin
              slow_q <= slow_sat;
              init_q <= 1'b0;
              if (slow_full) begin
                overflow_q <= 1'b1;
              end
            end
            if (bus.stop) begin
              stop_pend_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef AVG_PING_PONG_EN
  logic bank_q;

  // Host reads the opposite bank while the next run writes this one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank_q <= 1'b0;
    end else if (complete) begin
      bank_q <= ~bank_q;
    end
  end

  assign bus.bank = bank_q;
`else
  logic unused_complete;

  assign unused_complete = complete;
  assign bus.bank        = 1'b0;
`endif

  assign bus.fast_count = fast_q;
  assign bus.slow_count = slow_q;
  assign bus.init       = init_q;
  assign bus.wen        = wen_q;
  assign bus.ready      = ready_q;
  assign bus.n_avg      = n_avg_q;
  assign bus.overflow   = overflow_q;
  assign bus.address    = {fast_q, 2'b00};
endmodule

// File: tb/tb_averager_sequencer.sv
// Directed bench for averager_sequencer with a completion scoreboard (n_avg/overflow/bank).
// Small widths (FCW=5, SCW=3) keep runs short and make slow-count saturation reachable.
module tb_averager_sequencer;
  localparam int unsigned Fcw = 5;
  localparam int unsigned Scw = 3;

  typedef struct {
    int n_avg;
    int ovf;
  } exp_t;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;
  int   exp_bank;
  exp_t sb_q[$];

  averager_sequencer_if #(.FAST_COUNT_WIDTH(Fcw), .SLOW_COUNT_WIDTH(Scw)) bus ();

  averager_sequencer #(
    .FAST_COUNT_WIDTH(Fcw),
    .SLOW_COUNT_WIDTH(Scw)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 bus.restart = 1'b1;
    @(posedge clk); #1 bus.restart = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 bus.stop = 1'b1;
    @(posedge clk); #1 bus.stop = 1'b0;
  endtask

  // what: 0 ready, 1 wen, 2 slow_count, 3 overflow
  task automatic wait_for(input int what, input int val, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      case (what)
        0:       hit = (int'(bus.ready) == val);
        1:       hit = (int'(bus.wen) == val);
        2:       hit = (int'(bus.slow_count) == val);
        default: hit = (int'(bus.overflow) == val);
      endcase
    end
    chk({tag, "_reached"}, int'(hit), 1);
  endtask

  // Called at the first negedge with ready back high after a run.
  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
`ifdef AVG_PING_PONG_EN
      exp_bank = 1 - exp_bank;
`endif
      chk({tag, "_n_avg"}, int'(bus.n_avg), e.n_avg);
      chk({tag, "_overflow"}, int'(bus.overflow), e.ovf);
      chk({tag, "_wen_low"}, int'(bus.wen), 0);
      chk({tag, "_bank"}, int'(bus.bank), exp_bank);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, int'(bus.ready), 1);
    chk({tag, "_wen"}, int'(bus.wen), 0);
    chk({tag, "_init"}, int'(bus.init), 0);
    chk({tag, "_fast"}, int'(bus.fast_count), 0);
    chk({tag, "_slow"}, int'(bus.slow_count), 0);
    chk({tag, "_n_avg"}, int'(bus.n_avg), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
    chk({tag, "_bank"}, int'(bus.bank), 0);
    chk({tag, "_address"}, int'(bus.address), 0);
  endtask

  initial begin
    int wen_cyc;
    int init_cyc;
    int first_fc;
    bit seen;

    tests       = 0;
    fails       = 0;
    exp_bank    = 0;
    resetn      = 1'b0;
    bus.clken   = 1'b0;
    bus.restart = 1'b0;
    bus.stop    = 1'b0;
    bus.count_max = 5'd7;
    bus.n_avg_max = 3'd4;

    repeat (3) @(negedge clk);
    check_reset("reset");
    resetn    = 1'b1;
    bus.clken = 1'b1;
    // Initial count_max_reg is all-ones: let one 32-sample cycle pass to latch 7.
    repeat (40) @(negedge clk);

    // Fixed-length run: 4 cycles of 8 samples.
    bus.n_avg_max = 3'd4;
    sb_q.push_back('{n_avg: 4, ovf: 0});
    pulse_restart();
    @(negedge clk);
    chk("run4_ready_low", int'(bus.ready), 0);
    wen_cyc  = 0;
    init_cyc = 0;
    first_fc = -1;
    seen     = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.wen) begin
        if (first_fc < 0) first_fc = int'(bus.fast_count);
        wen_cyc++;
      end
      if (bus.init) init_cyc++;
      if (bus.ready) seen = 1'b1;
      else @(negedge clk);
    end
    chk("run4_reached", int'(seen), 1);
    chk("run4_first_fast", first_fc, 0);
    chk("run4_wen_cycles", wen_cyc, 32);
    chk("run4_init_cycles", init_cyc, 8);
    check_done("run4");

    // Continuous run stopped mid cycle 3.
    bus.n_avg_max = 3'd0;
    sb_q.push_back('{n_avg: 3, ovf: 0});
    pulse_restart();
    wait_for(2, 2, "stop_cyc3");
    chk("stop_address", int'(bus.address), int'(bus.fast_count) * 4);
    repeat (3) @(negedge clk);
    pulse_stop();
    wait_for(0, 1, "stop_done");
    check_done("stop");

    // Abort during cycle 2, re-run to completion.
    bus.n_avg_max = 3'd4;
    pulse_restart();
    wait_for(2, 1, "abort_cyc2");
    repeat (2) @(negedge clk);
    pulse_restart();
    @(negedge clk);
    chk("abort_wen", int'(bus.wen), 0);
    chk("abort_ready", int'(bus.ready), 0);
    chk("abort_n_avg", int'(bus.n_avg), 3);
    sb_q.push_back('{n_avg: 4, ovf: 0});
    wait_for(1, 1, "rerun_start");
    chk("rerun_fast", int'(bus.fast_count), 0);
    chk("rerun_init", int'(bus.init), 1);
    chk("rerun_slow", int'(bus.slow_count), 0);
    chk("rerun_n_avg_held", int'(bus.n_avg), 3);
    wait_for(0, 1, "rerun_done");
    check_done("rerun");

    // Continuous run through saturation of the 3-bit slow counter.
    bus.n_avg_max = 3'd0;
    sb_q.push_back('{n_avg: 7, ovf: 1});
    pulse_restart();
    wait_for(3, 1, "sat_overflow");
    chk("sat_slow", int'(bus.slow_count), 7);
    repeat (10) @(negedge clk);
    chk("sat_slow_held", int'(bus.slow_count), 7);
    pulse_stop();
    wait_for(0, 1, "sat_done");
    check_done("sat");
    chk("sb_empty", sb_q.size(), 0);

    // Asynchronous reset in the middle of a run.
    pulse_restart();
    wait_for(1, 1, "rst_run");
    repeat (5) @(negedge clk);
    chk("rst_pre_wen", int'(bus.wen), 1);
    resetn = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_bank = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
